// File: rtl/fsm_unit_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fsm_unit_pkg
// Brief    : State enum and Z encodings shared by the fsm_unit run-length FSM.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_unit_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    localparam logic [1:0] c_Z_S0 = 2'b00;
    localparam logic [1:0] c_Z_S1 = 2'b01;
    localparam logic [1:0] c_Z_S2 = 2'b10;
    localparam logic [1:0] c_Z_S3 = 2'b11;

endpackage : fsm_unit_pkg
`default_nettype wire

// File: rtl/fsm_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fsm_unit_if
// Brief    : Serial run input A and run-length status Z of fsm_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface fsm_unit_if;

    logic       A;
    logic [1:0] Z;

    modport master (output A, input  Z);
    modport slave  (input  A, output Z);

endinterface : fsm_unit_if
`default_nettype wire

// File: rtl/fsm_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fsm_unit
// Brief    : Moore run-length detector on serial input A, saturating at 3.
//            FSM_UNIT_DECAY_EN: A=0 steps down one state instead of clearing.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_unit
    import fsm_unit_pkg::*;
(
    input  wire logic   clock,
    input  wire logic   reset,
    fsm_unit_if.slave   bus
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_z;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S0;
        if (bus.A) begin
            case (r_state)
                S0:      w_next = S1;
                S1:      w_next = S2;
                S2:      w_next = S3;
                S3:      w_next = S3;
                default: w_next = S0;
            endcase
        end else begin
`ifdef FSM_UNIT_DECAY_EN
            case (r_state)
                S3:      w_next = S2;
                S2:      w_next = S1;
                S1:      w_next = S0;
                default: w_next = S0;
            endcase
`else
            w_next = S0;
`endif
        end
    end

    // Decoded from the state register alone so A never reaches Z combinationally.
    always_comb begin
        w_z = c_Z_S0;
        case (r_state)
            S0:      w_z = c_Z_S0;
            S1:      w_z = c_Z_S1;
            S2:      w_z = c_Z_S2;
            S3:      w_z = c_Z_S3;
            default: w_z = c_Z_S0;
        endcase
    end

    assign bus.Z = w_z;

endmodule : fsm_unit
`default_nettype wire

// File: tb/tb_fsm_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fsm_unit
// Brief    : Scoreboard bench for fsm_unit (default and FSM_UNIT_DECAY_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_unit;

    logic clk;
    logic rst;
    fsm_unit_if u_if ();

    fsm_unit u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int         n_checks;
    int         n_pass;
    int         model_state;
    logic [1:0] sb_q[$];

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int s, input logic a, input logic r);
        if (r)   return 0;
        if (a)   return (s >= 3) ? 3 : s + 1;
`ifdef FSM_UNIT_DECAY_EN
        return (s > 0) ? s - 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Drive on the falling edge, score 1 ns after the rising edge.
    task automatic step(input logic a, input logic r, input string tag);
        logic [1:0] exp_z;
        @(negedge clk);
        u_if.A = a;
        rst    = r;
        model_state = model_next(model_state, a, r);
        sb_q.push_back(2'(model_state));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_empty"}, u_if.Z, 2'bxx);
        end else begin
            exp_z = sb_q.pop_front();
            chk(tag, u_if.Z, exp_z);
        end
    endtask

    initial begin
        bit         saw_two;
        logic [1:0] held;
        n_checks    = 0;
        n_pass      = 0;
        model_state = 0;
        u_if.A      = 1'b0;
        rst         = 1'b1;

        step(1'b0, 1'b1, "reset");

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "run");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "drop");

        // Re-enter S1 then reset with A held high.
        step(1'b0, 1'b1, "pre_mid");
        step(1'b1, 1'b0, "mid_s1");
        step(1'b1, 1'b1, "mid_rst");
        step(1'b1, 1'b0, "mid_after");

        // Reset dominance from S3.
        step(1'b1, 1'b0, "s3_a");
        step(1'b1, 1'b0, "s3_b");
        step(1'b1, 1'b1, "s3_rst");

        // Glitch pattern from S0.
        saw_two = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step((i % 2) == 0, 1'b0, "glitch");
            if (u_if.Z == 2'b10) saw_two = 1'b1;
        end
        chk("glitch_no_10", {1'b0, saw_two}, 2'b00);

        // Reset raised between edges must not act until the next rising edge.
        step(1'b1, 1'b0, "async_pre1");
        step(1'b1, 1'b0, "async_pre2");
        held = 2'(model_state);
        @(negedge clk);
        rst    = 1'b1;
        u_if.A = 1'b1;
        #3 chk("async_hold_a", u_if.Z, held);
        #4 chk("async_hold_b", u_if.Z, held);
        model_state = 0;
        sb_q.push_back(2'b00);
        @(posedge clk);
        #1 chk("async_edge", u_if.Z, sb_q.pop_front());

        // Random soak.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fsm_unit
`default_nettype wire
